result_deskew: RTL

RESULT_DESKEW -- requirements
Module: result_deskew

---
 rtl/result_deskew.sv | 117 +++++++++++
 1 files changed

// File: rtl/result_deskew.sv
// Realigns skewed systolic-array column results into whole vectors and buffers
// them in a small FIFO for a downstream consumer with ready/valid handshake.
module result_deskew #(
    parameter int N_COLS     = 4,
    parameter int ACC_BITS   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               sys_clk,
    input  logic                               reset,
    input  logic [N_COLS-1:0]                  col_valid,
    input  logic [N_COLS*ACC_BITS-1:0]         col_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_COLS*ACC_BITS-1:0]         out_data,
    output logic                               overflow,
    output logic                               skew_err,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int VEC_W = N_COLS * ACC_BITS;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [N_COLS-1:0] aligned_valid;
    logic [VEC_W-1:0]  aligned_data;

    // Column j is delayed by N_COLS-1-j so that every column of a vector
    // lines up with the last column, which passes straight through.
    genvar j;
    generate
        for (j = 0; j < N_COLS; j++) begin : g_col
            localparam int DELAY = N_COLS - 1 - j;
            if (DELAY == 0) begin : g_direct
                assign aligned_valid[j] = col_valid[j];
                assign aligned_data[j*ACC_BITS +: ACC_BITS] = col_data[j*ACC_BITS +: ACC_BITS];
            end else begin : g_delay
                logic [DELAY-1:0]    valid_sr;
                logic [ACC_BITS-1:0] data_sr [DELAY];

                always_ff @(posedge sys_clk) begin
                    if (reset) begin
                        valid_sr <= '0;
                        for (int k = 0; k < DELAY; k++) begin
                            data_sr[k] <= '0;
                        end
                    end else begin
                        valid_sr[0] <= col_valid[j];
                        data_sr[0]  <= col_valid[j] ? col_data[j*ACC_BITS +: ACC_BITS] : '0;
                        for (int k = 1; k < DELAY; k++) begin
                            valid_sr[k] <= valid_sr[k-1];
                            data_sr[k]  <= data_sr[k-1];
                        end
                    end
                end

                assign aligned_valid[j] = valid_sr[DELAY-1];
                assign aligned_data[j*ACC_BITS +: ACC_BITS] = data_sr[DELAY-1];
            end
        end
    endgenerate

    logic push_req;
    logic misaligned;
    logic fifo_full;
    logic do_pop;
    logic do_push;

    assign push_req   = &aligned_valid;
    assign misaligned = (|aligned_valid) && !push_req;
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign do_pop     = out_valid && out_ready;
    // A full FIFO still accepts a vector when the head leaves on the same edge.
    assign do_push    = push_req && (!fifo_full || do_pop);

    logic [VEC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= aligned_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            skew_err   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !do_push) begin
                overflow <= 1'b1;
            end
            if (misaligned) begin
                skew_err <= 1'b1;
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

endmodule
